// File: rtl/bsg_link_channel_arbiter.sv
// Packet-atomic round-robin arbiter that shares one upstream link core port among els_p requesters.
// Optional per-requester packet counters are enabled with `define BSG_LINK_ARB_PERF_EN.

`ifdef BSG_LINK_ARB_PERF_EN
module bsg_link_arb_pkt_ctr (
  input  logic        clk_i,
  input  logic        clear_i,
  input  logic        inc_i,
  output logic [15:0] count_o
);
  logic [15:0] count_q;

  // Clear has priority over a coincident increment.
  always_ff @(posedge clk_i) begin
    if (clear_i)    count_q <= '0;
    else if (inc_i) count_q <= count_q + 16'd1;
  end

  assign count_o = count_q;
endmodule
`endif

module bsg_link_channel_arbiter #(
  parameter int els_p       = 4,
  parameter int width_p     = 64,
  parameter int len_width_p = 4
) (
  input  logic                     core_clk_i,
  input  logic                     core_reset_i,
  input  logic [els_p*width_p-1:0] req_data_i,
  input  logic [els_p-1:0]         req_valid_i,
  output logic [els_p-1:0]         req_ready_o,
  output logic [width_p-1:0]       link_data_o,
  output logic                     link_valid_o,
  input  logic                     link_ready_i,
  output logic [els_p-1:0]         grant_o
`ifdef BSG_LINK_ARB_PERF_EN
  ,
  input  logic                     perf_clear_i,
  output logic [els_p*16-1:0]      pkt_count_o
`endif
);
  localparam int PTR_W = $clog2(els_p);
  typedef logic [PTR_W-1:0] ptr_t;
  typedef enum logic {IDLE, BUSY} state_e;

  state_e                   state_q, state_d;
  ptr_t                     rr_ptr_q, rr_ptr_d, owner_q, owner_d, sel, cur;
  logic [len_width_p-1:0]   cnt_q, cnt_d, hdr_len;
  logic [els_p-1:0][width_p-1:0] req_data;
  logic                     hs;

  function automatic ptr_t ptr_inc(ptr_t p);
    if (p == ptr_t'(els_p - 1)) return '0;
    return p + 1'b1;
  endfunction

  function automatic ptr_t rr_idx(ptr_t base, int k);
    int j;
    j = int'(base) + k;
    if (j >= els_p) j = j - els_p;
    return ptr_t'(j);
  endfunction

  assign req_data = req_data_i;

  // Scan downward so the requester closest to rr_ptr_q is the last one written.
  always_comb begin
    sel = rr_ptr_q;
    for (int k = els_p - 1; k >= 0; k--) begin
      if (req_valid_i[rr_idx(rr_ptr_q, k)]) sel = rr_idx(rr_ptr_q, k);
    end
  end

  assign cur     = (state_q == BUSY) ? owner_q : sel;
  assign hdr_len = req_data[cur][len_width_p-1:0];

  always_comb begin
    link_valid_o = 1'b0;
    link_data_o  = '0;
    grant_o      = '0;
    req_ready_o  = '0;
    if (!core_reset_i) begin
      link_data_o = req_data[cur];
      if (state_q == BUSY) begin
        link_valid_o         = req_valid_i[owner_q];
        grant_o[owner_q]     = 1'b1;
        req_ready_o[owner_q] = link_ready_i;
      end else if (|req_valid_i) begin
        link_valid_o     = 1'b1;
        grant_o[sel]     = 1'b1;
        req_ready_o[sel] = link_ready_i;
      end
    end
  end

  assign hs = link_valid_o & link_ready_i;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    if (hs) begin
      if (state_q == IDLE) begin
        if (hdr_len == '0) begin
          rr_ptr_d = ptr_inc(sel);
        end else begin
          state_d = BUSY;
          owner_d = sel;
          cnt_d   = hdr_len;
        end
      end else if (cnt_q == len_width_p'(1)) begin
        state_d  = IDLE;
        rr_ptr_d = ptr_inc(owner_q);
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge core_clk_i) begin
    if (core_reset_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef BSG_LINK_ARB_PERF_EN
  // Final flit: a zero-length header, or the body flit that drains cnt_q.
  logic last;
  assign last = hs & (((state_q == IDLE) && (hdr_len == '0)) ||
                      ((state_q == BUSY) && (cnt_q == len_width_p'(1))));

  for (genvar i = 0; i < els_p; i++) begin : g_ctr
    bsg_link_arb_pkt_ctr u_ctr (
      .clk_i   (core_clk_i),
      .clear_i (core_reset_i | perf_clear_i),
      .inc_i   (last && (cur == ptr_t'(i))),
      .count_o (pkt_count_o[i*16 +: 16])
    );
  end
`endif
endmodule

// File: tb/tb_bsg_link_channel_arbiter.sv
// Directed + randomized bench for bsg_link_channel_arbiter; per-requester flit queues drive a
// packet-level reference model (owner / remaining flits / next-priority index).

module tb_bsg_link_channel_arbiter;
  localparam int N = 4, W = 64, LW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, link_ready, link_valid;
  logic [N*W-1:0]     req_data;
  logic [N-1:0]       req_valid, req_ready, grant;
  logic [W-1:0]       link_data;
`ifdef BSG_LINK_ARB_PERF_EN
  logic               perf_clear;
  logic [N*16-1:0]    pkt_count;
`endif

  bsg_link_channel_arbiter #(.els_p(N), .width_p(W), .len_width_p(LW)) dut (
    .core_clk_i   (clk),
    .core_reset_i (rst),
    .req_data_i   (req_data),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .link_data_o  (link_data),
    .link_valid_o (link_valid),
    .link_ready_i (link_ready),
    .grant_o      (grant)
`ifdef BSG_LINK_ARB_PERF_EN
    ,
    .perf_clear_i (perf_clear),
    .pkt_count_o  (pkt_count)
`endif
  );

  logic [W-1:0] q[N][$];
  logic [N-1:0] en, acc;
  logic [N-1:0] obs_grant, obs_ready;
  logic         obs_valid;
  int           n_cmp = 0, n_err = 0;
  int           m_rr = 0, m_owner = -1, m_cnt = 0;
  logic [15:0]  m_pkt[N];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int r, input int len);
    logic [W-1:0] f;
    f = {$urandom, $urandom};
    f[LW-1:0] = LW'(len);
    q[r].push_back(f);
    for (int b = 0; b < len; b++) q[r].push_back({$urandom, $urandom});
  endtask

  // One clock: drive from queues, compare against the model, then retire the accepted flit.
  task automatic tick();
    int g;
    bit v, hs, fin;
    logic [LW-1:0] len;
    logic [W-1:0] ep;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = en[i] && (q[i].size() > 0);
      req_data[i*W +: W] = (q[i].size() > 0) ? q[i][0] : '0;
    end
    #1;
    g = -1;
    v = 0;
    if (!rst) begin
      if (m_owner >= 0) begin
        g = m_owner;
        v = req_valid[g];
      end else begin
        for (int k = 0; k < N; k++)
          if (g < 0 && req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
        v = (g >= 0);
      end
    end
    hs = v && link_ready;
    obs_grant = grant;
    obs_ready = req_ready;
    obs_valid = link_valid;
    chk("link_valid", W'(link_valid), W'(v));
    chk("grant", W'(grant), (g >= 0) ? (64'(1) << g) : '0);
    chk("req_ready", W'(req_ready), (g >= 0 && link_ready) ? (64'(1) << g) : '0);
    if (v) chk("link_data", link_data, q[g][0]);
    else if (rst) chk("rst_data", link_data, '0);
`ifdef BSG_LINK_ARB_PERF_EN
    ep = '0;
    for (int i = 0; i < N; i++) ep[i*16 +: 16] = m_pkt[i];
    chk("pkt_count", pkt_count, ep);
`else
    ep = '0;
`endif
    @(posedge clk);
    @(negedge clk);
    acc = '0;
    fin = 0;
    if (rst) begin
      m_rr = 0;
      m_owner = -1;
      m_cnt = 0;
    end else if (hs) begin
      len = q[g][0][LW-1:0];
      acc[g] = 1'b1;
      if (m_owner < 0) begin
        if (len == 0) begin
          m_rr = (g + 1) % N;
          fin = 1;
        end else begin
          m_owner = g;
          m_cnt = int'(len);
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_owner = -1;
          m_rr = (g + 1) % N;
          fin = 1;
        end
      end
      void'(q[g].pop_front());
    end
`ifdef BSG_LINK_ARB_PERF_EN
    if (rst || perf_clear) begin
      for (int i = 0; i < N; i++) m_pkt[i] = '0;
    end else if (fin) begin
      m_pkt[g] = m_pkt[g] + 16'd1;
    end
`endif
  endtask

  initial begin
    int r;
    rst = 1'b1;
    link_ready = 1'b1;
    en = '1;
    req_valid = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) m_pkt[i] = '0;
`ifdef BSG_LINK_ARB_PERF_EN
    perf_clear = 1'b0;
`endif
    @(negedge clk);

    // Reset with req 2 already waiting, then a single-flit grant from IDLE.
    push(2, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("single_req2_grant", W'(obs_grant), W'(4'b0100));

    // Round-robin over single-flit packets, starting at pointer 3.
    for (int i = 0; i < N; i++) begin
      push(i, 0);
      push(i, 0);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr_seq", W'(obs_grant), 64'(1) << ((3 + k) % N));
    end

    // Atomicity: req 1 len=3 holds off everyone, then priority resumes from 2.
    push(1, 3);
    tick();
    push(0, 0);
    push(2, 0);
    push(3, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("atomic_grant", W'(obs_grant), W'(4'b0010));
      chk("atomic_rdy0", W'(obs_ready[0]), '0);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_atomic_seq", W'(obs_grant), 64'(1) << ((2 + k) % N));
    end

    // Backpressure then owner gap with cnt at 2; lock must hold.
    push(1, 3);
    tick();
    tick();
    push(0, 0);
    link_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("stall_grant", W'(obs_grant), W'(4'b0010));
    end
    link_ready = 1'b1;
    en[1] = 1'b0;
    repeat (2) begin
      tick();
      chk("gap_grant", W'(obs_grant), W'(4'b0010));
      chk("gap_valid", W'(obs_valid), '0);
    end
    en[1] = 1'b1;
    tick();
    tick();
    tick();
    chk("after_gap_req0", W'(obs_grant), W'(4'b0001));

    // Reset in the middle of a req 3 len=5 packet.
    push(3, 5);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_valid", W'(obs_valid), '0);
    chk("midrst_grant", W'(obs_grant), '0);
    tick();
    for (int i = 0; i < N; i++) q[i].delete();
    rst = 1'b0;
    push(0, 0);
    push(3, 0);
    tick();
    chk("postrst_req0", W'(obs_grant), W'(4'b0001));
    tick();
    chk("postrst_req3", W'(obs_grant), W'(4'b1000));

`ifdef BSG_LINK_ARB_PERF_EN
    push(1, 0);
    push(1, 2);
    push(1, 1);
    repeat (6) tick();
    chk("perf_req1_3", W'(pkt_count[31:16]), W'(16'd3));
    push(1, 0);
    perf_clear = 1'b1;
    tick();
    perf_clear = 1'b0;
    chk("perf_req1_clr", W'(pkt_count[31:16]), '0);
`endif

    // Randomized traffic with backpressure, gaps, max-length packets and rare resets.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      link_ready = ($urandom_range(0, 3) != 0);
`ifdef BSG_LINK_ARB_PERF_EN
      perf_clear = ($urandom_range(0, 99) == 0);
`endif
      for (int i = 0; i < N; i++) begin
        if (q[i].size() < 3 && $urandom_range(0, 3) == 0) begin
          r = $urandom_range(0, 3);
          push(i, (r == 0) ? 0 : (r == 1) ? 15 : $urandom_range(0, 15));
        end
        // A presented, unaccepted flit stays valid.
        en[i] = (req_valid[i] && !acc[i]) ? 1'b1 : ($urandom_range(0, 4) != 0);
      end
      tick();
      if (rst) for (int i = 0; i < N; i++) q[i].delete();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
